rv_multicycle_ctrl: RTL and testbench
=====================================

# rv_multicycle_ctrl

Multi-cycle control unit for the RV32I core. It replaces the single-cycle combinational controller with a Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles on one shared memory port. It adds memory wait-state handshaking, a bounded wait timeout, full RV32I control-flow support (JAL/JALR/LUI/AUIPC, all six branches, SRA/SRAI) and illegal-instruction trapping. It sits between the instruction register and the datapath muxes, register file, ALU and memory port.

## Interface
- `WAIT_LIMIT`, default 16: maximum cycles spent in one memory state without `mem_ready`; 0 disables the timeout.
- `ALU_CTRL_W`, default 4: width of `alu_control`.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 7, `funct3` in 3, `funct7` in 7: fields of the latched instruction register.
- `alu_zero` in 1: ALU result == 0, combinational from the current ALU result.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: store.
- `addr_src` out 1: memory address source; 0 = PC, 1 = ALUOut.
- `pc_write` out 1: PC load enable.
- `ir_write` out 1: IR and oldPC load enable.
- `regwrite` out 1: register file write enable.
- `alu_src_a` out 2: ALU A operand; 0 = PC, 1 = oldPC, 2 = rs1.
- `alu_src_b` out 2: ALU B operand; 0 = rs2, 1 = imm, 2 = constant 4.
- `result_src` out 2: result bus source; 0 = ALUOut, 1 = memory data, 2 = ALU direct.
- `imm_sel` out 3: immediate format; 0 = I, 1 = S, 2 = B, 3 = U, 4 = J.
- `alu_control` out ALU_CTRL_W: 0 add, 1 sub, 2 and, 3 or, 4 slt, 5 xor, 6 sltu, 7 sll, 8 srl, 9 sra, 10 pass_b.
- `trap` out 1: core halted.
- `illegal_instr` out 1: trap cause is an illegal instruction.
- `mem_err` out 1: trap cause is a memory timeout.

## Operation
- States:
  - IDLE (entered on reset)
  - FETCH
  - DECODE
  - MEM_ADDR, MEM_RD, MEM_WB, MEM_WR
  - EXEC_R, EXEC_I
  - ALU_WB
  - BRANCH
  - JALR_ADDR, JUMP
  - LUI, AUIPC
  - TRAP
- Unlisted outputs are 0 in every state.
- IDLE: all outputs 0. Moves to FETCH the next cycle.
- FETCH:
  - Drives mem_req=1, addr_src=0, alu_src_a=0, alu_src_b=2, add, result_src=2.
  - ir_write and pc_write equal mem_ready.
  - Stays in FETCH until mem_ready, then moves to DECODE.
- DECODE:
  - Computes ALUOut = oldPC + B-immediate (a=1, b=1, imm_sel=2, add).
  - Dispatches on opcode: 0000011→MEM_ADDR, 0100011→MEM_ADDR, 0110011→EXEC_R, 0010011→EXEC_I, 1100011→BRANCH, 1101111→JUMP, 1100111→JALR_ADDR, 0110111→LUI, 0010111→AUIPC.
  - Any other opcode goes to TRAP with illegal_instr set.
- MEM_ADDR: a=2, b=1, add. imm_sel is I for loads, S for stores. Loads go to MEM_RD, stores to MEM_WR.
- MEM_RD: mem_req=1, addr_src=1. Waits for mem_ready, then goes to MEM_WB.
- MEM_WB: result_src=1, regwrite=1. Goes to FETCH.
- MEM_WR: mem_req=1, mem_we=1, addr_src=1. Waits for mem_ready, then goes to FETCH.
- EXEC_R / EXEC_I: a=2, b=0 (R) or 1 (I). Goes to ALU_WB.
- ALU_WB: result_src=0, regwrite=1. Goes to FETCH.
- BRANCH:
  - a=2, b=0.
  - funct3 000/001 use sub; 100/101 use slt; 110/111 use sltu.
  - result_src=0; pc_write = alu_zero ^ funct3[0] ^ funct3[2].
  - funct3 010/011 go to TRAP (illegal). Otherwise goes to FETCH.
- JALR_ADDR: a=2, b=1, imm_sel=0, add. Goes to JUMP.
- JUMP:
  - a=1, b=2, add, result_src=0, pc_write=1. ALUOut holds the target.
  - For JAL, imm_sel=4 in DECODE so ALUOut = oldPC + J-immediate.
  - Goes to ALU_WB, which writes oldPC+4.
- LUI: b=1, imm_sel=3, pass_b, result_src=2, regwrite=1. Goes to FETCH.
- AUIPC: a=1, b=1, imm_sel=3, add, result_src=2, regwrite=1. Goes to FETCH.
- ALU decode, applied in EXEC_R and EXEC_I:
  - funct3 000: sub only when R-type and funct7=0100000. I-type addi ignores funct7.
  - funct3 101: sra when funct7[5]=1, otherwise srl.
  - R-type with funct7 other than 0000000 / 0100000, or 0100000 on a funct3 other than 000/101, goes to TRAP (illegal) instead of ALU_WB.
- Timeout:
  - A wait counter clears on entry to FETCH, MEM_RD or MEM_WR and increments on each cycle without mem_ready.
  - On reaching WAIT_LIMIT (when WAIT_LIMIT≠0), the FSM goes to TRAP with mem_err=1.
  - Counter width is clog2(WAIT_LIMIT+1).
- TRAP:
  - trap=1, all enables 0. Cause flags are registered and held.
  - Only reset exits TRAP.

## Timing
- Outputs are Moore, decoded from the registered state. The exceptions are the mem_ready-qualified pc_write/ir_write in FETCH and the alu_zero-qualified pc_write in BRANCH.
- Latency with zero-wait memory (mem_ready=1 on the first request cycle), in cycles:
  - R, I, LUI, AUIPC: 4, except LUI/AUIPC take 3.
  - Load: 5
  - Store: 4
  - Branch: 3
  - JAL: 4
  - JALR: 5
- Each wait cycle adds one cycle.
- rst_n low forces IDLE asynchronously, from any state including mid-access. All outputs read 0, and the trap flags and wait counter clear.
- mem_ready outside FETCH, MEM_RD and MEM_WR is ignored.

## Structure
- `rv_ctrl_pkg` holds:
  - state enum
  - opcode localparams
  - `alu_ctrl_e`
  - imm_sel, alu_src and result_src encodings
- One sub-module, `rv_alu_decoder`: combinational; inputs alu_op, is_rtype, funct3, funct7; outputs alu_control and illegal.

## Test plan
- Zero-wait `add x3,x1,x2` (funct7=0): states FETCH, DECODE, EXEC_R, ALU_WB. regwrite=1 only in cycle 4 with alu_control=0.
- Load with mem_ready low for 3 cycles in MEM_RD: 8 cycles total. mem_req stays 1 and addr_src=1 throughout.
- `bge` (funct3=101) with alu_zero=1: pc_write=1 in BRANCH. Same with alu_zero=0: pc_write=0. alu_control=4 in both.
- `srai` (opcode 0010011, funct3=101, funct7=0100000): alu_control=9. `addi` with funct7=0100000: alu_control=0.
- WAIT_LIMIT=16, mem_ready held 0 in FETCH: after 16 cycles trap=1 and mem_err=1, held until rst_n pulses low. Then IDLE with all outputs 0.
- opcode 1111111: TRAP with illegal_instr=1 the cycle after DECODE. Asserting rst_n low mid-load returns the FSM to IDLE immediately.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared types and encodings for the RV32I multi-cycle controller:
// FSM state enum, opcode and funct7 values, ALU operation codes, the
// controller-to-ALU-decoder operation class, and the datapath mux
// select encodings (immediate format, ALU operands, result bus).
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
    S_BRANCH,
    S_JALR_ADDR,
    S_JUMP,
    S_LUI,
    S_AUIPC,
    S_TRAP
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_SLT    = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SLTU   = 4'd6,
    ALU_SLL    = 4'd7,
    ALU_SRL    = 4'd8,
    ALU_SRA    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_ctrl_e;

  // Operation class the FSM hands to the ALU decoder.
  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_BRANCH,
    ALUOP_FUNCT,
    ALUOP_PASS
  } alu_op_e;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] ASRC_PC    = 2'd0;
  localparam logic [1:0] ASRC_OLDPC = 2'd1;
  localparam logic [1:0] ASRC_RS1   = 2'd2;

  localparam logic [1:0] BSRC_RS2  = 2'd0;
  localparam logic [1:0] BSRC_IMM  = 2'd1;
  localparam logic [1:0] BSRC_FOUR = 2'd2;

  localparam logic [1:0] RES_ALUOUT = 2'd0;
  localparam logic [1:0] RES_MEM    = 2'd1;
  localparam logic [1:0] RES_ALU    = 2'd2;

endpackage

// File: rtl/rv_alu_decoder.sv
// Combinational ALU operation decoder.
//   alu_op      : operation class from the controller FSM
//   is_rtype    : funct7 is significant (OP opcode)
//   funct3/7    : instruction fields
//   alu_control : ALU operation
//   illegal     : encoding not valid for this operation class
module rv_alu_decoder
  import rv_ctrl_pkg::*;
(
  input  alu_op_e     alu_op,
  input  logic        is_rtype,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  output alu_ctrl_e   alu_control,
  output logic        illegal
);

  always_comb begin
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    unique case (alu_op)
      ALUOP_ADD:  alu_control = ALU_ADD;
      ALUOP_PASS: alu_control = ALU_PASS_B;
      ALUOP_BRANCH: begin
        // beq/bne compare by subtraction, signed/unsigned ordering by slt/sltu.
        unique case (funct3[2:1])
          2'b00:   alu_control = ALU_SUB;
          2'b10:   alu_control = ALU_SLT;
          2'b11:   alu_control = ALU_SLTU;
          default: illegal = 1'b1;
        endcase
      end
      ALUOP_FUNCT: begin
        unique case (funct3)
          3'b000:  alu_control = (is_rtype && funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
        if (is_rtype)
          illegal = !((funct7 == F7_BASE) ||
                      (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)));
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle Moore control FSM for an RV32I core sharing one memory port.
//   clk, rst_n                : clock, async active-low reset
//   opcode, funct3, funct7    : latched instruction fields
//   alu_zero, mem_ready       : ALU zero flag, memory access completion
//   mem_req, mem_we, addr_src : memory port control
//   pc_write, ir_write, regwrite : state element enables
//   alu_src_a/b, result_src, imm_sel, alu_control : datapath selects
//   trap, illegal_instr, mem_err : halt status and registered cause
module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 16,
  parameter int unsigned ALU_CTRL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic                  alu_zero,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  addr_src,
  output logic                  pc_write,
  output logic                  ir_write,
  output logic                  regwrite,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            result_src,
  output logic [2:0]            imm_sel,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  trap,
  output logic                  illegal_instr,
  output logic                  mem_err
);

  localparam int unsigned CW = (WAIT_LIMIT == 0) ? 1 : $clog2(WAIT_LIMIT + 1);

  state_e        state, state_next;
  logic [CW-1:0] wait_cnt;
  logic          in_wait, timeout;
  logic          set_ill, set_merr;
  logic          ill_q, merr_q;
  alu_op_e       alu_op;
  alu_ctrl_e     dec_ctrl;
  logic          dec_illegal;

  rv_alu_decoder u_alu_dec (
    .alu_op      (alu_op),
    .is_rtype    (state == S_EXEC_R),
    .funct3      (funct3),
    .funct7      (funct7),
    .alu_control (dec_ctrl),
    .illegal     (dec_illegal)
  );

  assign alu_control   = ALU_CTRL_W'(dec_ctrl);
  assign illegal_instr = ill_q;
  assign mem_err       = merr_q;
  assign in_wait       = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  // Fires on the WAIT_LIMIT-th consecutive cycle without mem_ready.
  assign timeout       = (WAIT_LIMIT != 0) && !mem_ready &&
                         (wait_cnt == CW'(WAIT_LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      ill_q    <= 1'b0;
      merr_q   <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next != state)
        wait_cnt <= '0;
      else if (in_wait && !mem_ready)
        wait_cnt <= wait_cnt + CW'(1);
      if (set_ill)  ill_q  <= 1'b1;
      if (set_merr) merr_q <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    alu_op     = ALUOP_ADD;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_src   = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    regwrite   = 1'b0;
    alu_src_a  = ASRC_PC;
    alu_src_b  = BSRC_RS2;
    result_src = RES_ALUOUT;
    imm_sel    = IMM_I;
    trap       = 1'b0;
    set_ill    = 1'b0;
    set_merr   = 1'b0;

    unique case (state)
      S_IDLE: state_next = S_FETCH;
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = BSRC_FOUR;
        result_src = RES_ALU;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_next = S_DECODE;
        else if (timeout) begin state_next = S_TRAP; set_merr = 1'b1; end
      end
      S_DECODE: begin
        // Speculative branch/JAL target into ALUOut while dispatching.
        alu_src_a = ASRC_OLDPC;
        alu_src_b = BSRC_IMM;
        imm_sel   = (opcode == OP_JAL) ? IMM_J : IMM_B;
        unique case (opcode)
          OP_LOAD, OP_STORE: state_next = S_MEM_ADDR;
          OP_OP:             state_next = S_EXEC_R;
          OP_IMM:            state_next = S_EXEC_I;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JUMP;
          OP_JALR:           state_next = S_JALR_ADDR;
          OP_LUI:            state_next = S_LUI;
          OP_AUIPC:          state_next = S_AUIPC;
          default: begin state_next = S_TRAP; set_ill = 1'b1; end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a  = ASRC_RS1;
        alu_src_b  = BSRC_IMM;
        imm_sel    = (opcode == OP_STORE) ? IMM_S : IMM_I;
        state_next = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req  = 1'b1;
        addr_src = 1'b1;
        if (mem_ready) state_next = S_MEM_WB;
        else if (timeout) begin state_next = S_TRAP; set_merr = 1'b1; end
      end
      S_MEM_WB: begin
        result_src = RES_MEM;
        regwrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_src = 1'b1;
        if (mem_ready) state_next = S_FETCH;
        else if (timeout) begin state_next = S_TRAP; set_merr = 1'b1; end
      end
      S_EXEC_R, S_EXEC_I: begin
        alu_op    = ALUOP_FUNCT;
        alu_src_a = ASRC_RS1;
        alu_src_b = (state == S_EXEC_R) ? BSRC_RS2 : BSRC_IMM;
        if (dec_illegal) begin state_next = S_TRAP; set_ill = 1'b1; end
        else state_next = S_ALU_WB;
      end
      S_ALU_WB: begin
        result_src = RES_ALUOUT;
        regwrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_op     = ALUOP_BRANCH;
        alu_src_a  = ASRC_RS1;
        alu_src_b  = BSRC_RS2;
        result_src = RES_ALUOUT;
        // funct3[0] inverts the sense; for slt/sltu "taken" means result != 0.
        if (dec_illegal) begin state_next = S_TRAP; set_ill = 1'b1; end
        else begin
          pc_write   = alu_zero ^ funct3[0] ^ funct3[2];
          state_next = S_FETCH;
        end
      end
      S_JALR_ADDR: begin
        alu_src_a  = ASRC_RS1;
        alu_src_b  = BSRC_IMM;
        imm_sel    = IMM_I;
        state_next = S_JUMP;
      end
      S_JUMP: begin
        // PC takes the target in ALUOut while the ALU forms oldPC+4 for the link.
        alu_src_a  = ASRC_OLDPC;
        alu_src_b  = BSRC_FOUR;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
        state_next = S_ALU_WB;
      end
      S_LUI: begin
        alu_op     = ALUOP_PASS;
        alu_src_b  = BSRC_IMM;
        imm_sel    = IMM_U;
        result_src = RES_ALU;
        regwrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_AUIPC: begin
        alu_src_a  = ASRC_OLDPC;
        alu_src_b  = BSRC_IMM;
        imm_sel    = IMM_U;
        result_src = RES_ALU;
        regwrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_TRAP: trap = 1'b1;
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Self-checking bench for rv_multicycle_ctrl. Each scenario queues the
// expected per-cycle output vector together with that cycle's stimulus,
// then drains the queue, comparing DUT outputs at the falling edge.
module tb_rv_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic       alu_zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, addr_src, pc_write, ir_write, regwrite;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] imm_sel;
  logic [3:0] alu_control;
  logic       trap, illegal_instr, mem_err;

  int checks = 0;
  int errors = 0;

  rv_multicycle_ctrl #(.WAIT_LIMIT(16), .ALU_CTRL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .addr_src(addr_src), .pc_write(pc_write), .ir_write(ir_write), .regwrite(regwrite),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .imm_sel(imm_sel), .alu_control(alu_control), .trap(trap),
    .illegal_instr(illegal_instr), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req, mem_we, addr_src, pc_write, ir_write, regwrite;
    logic [1:0] a, b, rs;
    logic [2:0] imm;
    logic [3:0] alu;
    logic       trap, ill, merr;
  } outs_t;

  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       rdy, z;
    outs_t      exp;
  } rec_t;

  typedef enum {T_IDLE, T_FETCH, T_DECODE, T_MEM_ADDR, T_MEM_RD, T_MEM_WB, T_MEM_WR,
                T_EXEC_R, T_EXEC_I, T_ALU_WB, T_BRANCH, T_JALR_ADDR, T_JUMP, T_LUI,
                T_AUIPC, T_TRAP_ILL, T_TRAP_MEM} tst_e;

  rec_t       sb[$];
  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic [6:0] cur_f7;

  function automatic outs_t dut_outs();
    return {mem_req, mem_we, addr_src, pc_write, ir_write, regwrite, alu_src_a,
            alu_src_b, result_src, imm_sel, alu_control, trap, illegal_instr, mem_err};
  endfunction

  // RV32I ALU operation for OP / OP-IMM instructions.
  function automatic logic [3:0] alu_of(logic [2:0] f3, logic [6:0] f7, logic r);
    case (f3)
      3'd0: return (r && f7 == 7'b0100000) ? 4'd1 : 4'd0;
      3'd1: return 4'd7;
      3'd2: return 4'd4;
      3'd3: return 4'd6;
      3'd4: return 4'd5;
      3'd5: return f7[5] ? 4'd9 : 4'd8;
      3'd6: return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  function automatic outs_t model(tst_e s, logic [6:0] op, logic [2:0] f3,
                                  logic [6:0] f7, logic rdy, logic z);
    outs_t o = '0;
    case (s)
      T_FETCH: begin
        o.mem_req = 1; o.b = 2; o.rs = 2; o.ir_write = rdy; o.pc_write = rdy;
      end
      T_DECODE:    begin o.a = 1; o.b = 1; o.imm = (op == 7'b1101111) ? 3'd4 : 3'd2; end
      T_MEM_ADDR:  begin o.a = 2; o.b = 1; o.imm = (op == 7'b0100011) ? 3'd1 : 3'd0; end
      T_MEM_RD:    begin o.mem_req = 1; o.addr_src = 1; end
      T_MEM_WB:    begin o.rs = 1; o.regwrite = 1; end
      T_MEM_WR:    begin o.mem_req = 1; o.mem_we = 1; o.addr_src = 1; end
      T_EXEC_R:    begin o.a = 2; o.b = 0; o.alu = alu_of(f3, f7, 1'b1); end
      T_EXEC_I:    begin o.a = 2; o.b = 1; o.alu = alu_of(f3, f7, 1'b0); end
      T_ALU_WB:    begin o.rs = 0; o.regwrite = 1; end
      T_BRANCH: begin
        o.a = 2; o.b = 0;
        o.alu = f3[2] ? (f3[1] ? 4'd6 : 4'd4) : 4'd1;
        o.pc_write = z ^ f3[0] ^ f3[2];
      end
      T_JALR_ADDR: begin o.a = 2; o.b = 1; o.imm = 0; end
      T_JUMP:      begin o.a = 1; o.b = 2; o.pc_write = 1; end
      T_LUI:       begin o.b = 1; o.imm = 3; o.alu = 4'd10; o.rs = 2; o.regwrite = 1; end
      T_AUIPC:     begin o.a = 1; o.b = 1; o.imm = 3; o.rs = 2; o.regwrite = 1; end
      T_TRAP_ILL:  begin o.trap = 1; o.ill = 1; end
      T_TRAP_MEM:  begin o.trap = 1; o.merr = 1; end
      default:     o = '0;
    endcase
    return o;
  endfunction

  task automatic instr(logic [6:0] op, logic [2:0] f3, logic [6:0] f7);
    cur_op = op; cur_f3 = f3; cur_f7 = f7;
  endtask

  task automatic push(tst_e s, logic rdy = 1'b0, logic z = 1'b0);
    rec_t r;
    r.op = cur_op; r.f3 = cur_f3; r.f7 = cur_f7; r.rdy = rdy; r.z = z;
    r.exp = model(s, cur_op, cur_f3, cur_f7, rdy, z);
    sb.push_back(r);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    outs_t got;
    #2 rst_n = 1'b0;
    mem_ready = 1'b1; opcode = 7'b0110011;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      got = dut_outs();
      checks++;
      if (got !== outs_t'(0)) begin
        errors++; $display("FAIL reset_hold got %h expected %h", got, outs_t'(0));
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_alu_ops();
    rec_t r; outs_t got; int n = 0;
    instr(7'b0110011, 3'b000, 7'b0000000);            // add
    push(T_IDLE); push(T_FETCH, 1); push(T_DECODE); push(T_EXEC_R); push(T_ALU_WB);
    instr(7'b0110011, 3'b000, 7'b0100000);            // sub
    push(T_FETCH, 1); push(T_DECODE); push(T_EXEC_R); push(T_ALU_WB);
    instr(7'b0010011, 3'b101, 7'b0100000);            // srai
    push(T_FETCH, 1); push(T_DECODE); push(T_EXEC_I); push(T_ALU_WB);
    instr(7'b0010011, 3'b000, 7'b0100000);            // addi, funct7 ignored
    push(T_FETCH, 1); push(T_DECODE); push(T_EXEC_I); push(T_ALU_WB);
    instr(7'b0110011, 3'b101, 7'b0100000);            // sra
    push(T_FETCH, 1); push(T_DECODE); push(T_EXEC_R); push(T_ALU_WB);
    instr(7'b0110011, 3'b111, 7'b0000000);            // and
    push(T_FETCH, 1); push(T_DECODE); push(T_EXEC_R); push(T_ALU_WB);
    push(T_FETCH, 0);
    while (sb.size() != 0) begin
      r = sb.pop_front();
      opcode = r.op; funct3 = r.f3; funct7 = r.f7; mem_ready = r.rdy; alu_zero = r.z;
      @(negedge clk);
      got = dut_outs(); checks++;
      if (got !== r.exp) begin
        errors++; $display("FAIL alu_ops step %0d got %h expected %h", n, got, r.exp);
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_memory();
    rec_t r; outs_t got; int n = 0;
    apply_reset();
    instr(7'b0000011, 3'b010, 7'b0000000);            // lw, 3 wait cycles
    push(T_IDLE); push(T_FETCH, 1); push(T_DECODE); push(T_MEM_ADDR);
    push(T_MEM_RD, 0); push(T_MEM_RD, 0); push(T_MEM_RD, 0); push(T_MEM_RD, 1);
    push(T_MEM_WB);
    instr(7'b0100011, 3'b010, 7'b0000000);            // sw after a fetch wait
    push(T_FETCH, 0); push(T_FETCH, 1); push(T_DECODE); push(T_MEM_ADDR);
    push(T_MEM_WR, 1, 1);
    push(T_FETCH, 0);
    while (sb.size() != 0) begin
      r = sb.pop_front();
      opcode = r.op; funct3 = r.f3; funct7 = r.f7; mem_ready = r.rdy; alu_zero = r.z;
      @(negedge clk);
      got = dut_outs(); checks++;
      if (got !== r.exp) begin
        errors++; $display("FAIL memory step %0d got %h expected %h", n, got, r.exp);
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    rec_t r; outs_t got; int n = 0;
    instr(7'b1100011, 3'b101, 7'b0000000);            // bge taken / not taken
    push(T_FETCH, 1); push(T_DECODE, 1, 0); push(T_BRANCH, 1, 1);
    push(T_FETCH, 1); push(T_DECODE); push(T_BRANCH, 0, 0);
    instr(7'b1100011, 3'b000, 7'b0000000);            // beq equal
    push(T_FETCH, 1); push(T_DECODE); push(T_BRANCH, 0, 1);
    instr(7'b1100011, 3'b110, 7'b0000000);            // bltu, less-than result
    push(T_FETCH, 1); push(T_DECODE); push(T_BRANCH, 0, 0);
    instr(7'b1100011, 3'b001, 7'b0000000);            // bne equal -> not taken
    push(T_FETCH, 1); push(T_DECODE); push(T_BRANCH, 0, 1);
    push(T_FETCH, 0);
    while (sb.size() != 0) begin
      r = sb.pop_front();
      opcode = r.op; funct3 = r.f3; funct7 = r.f7; mem_ready = r.rdy; alu_zero = r.z;
      @(negedge clk);
      got = dut_outs(); checks++;
      if (got !== r.exp) begin
        errors++; $display("FAIL branch step %0d got %h expected %h", n, got, r.exp);
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jumps();
    rec_t r; outs_t got; int n = 0;
    instr(7'b1101111, 3'b000, 7'b0000000);            // jal
    push(T_FETCH, 1); push(T_DECODE); push(T_JUMP); push(T_ALU_WB);
    instr(7'b1100111, 3'b000, 7'b0000000);            // jalr
    push(T_FETCH, 1); push(T_DECODE); push(T_JALR_ADDR); push(T_JUMP); push(T_ALU_WB);
    instr(7'b0110111, 3'b000, 7'b0000000);            // lui
    push(T_FETCH, 1); push(T_DECODE); push(T_LUI);
    instr(7'b0010111, 3'b000, 7'b0000000);            // auipc
    push(T_FETCH, 1); push(T_DECODE); push(T_AUIPC);
    push(T_FETCH, 0);
    while (sb.size() != 0) begin
      r = sb.pop_front();
      opcode = r.op; funct3 = r.f3; funct7 = r.f7; mem_ready = r.rdy; alu_zero = r.z;
      @(negedge clk);
      got = dut_outs(); checks++;
      if (got !== r.exp) begin
        errors++; $display("FAIL jumps step %0d got %h expected %h", n, got, r.exp);
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    rec_t r; outs_t got; int n = 0;
    for (int k = 0; k < 3; k++) begin
      apply_reset();
      case (k)
        0: instr(7'b1111111, 3'b000, 7'b0000000);     // unknown opcode
        1: instr(7'b1100011, 3'b010, 7'b0000000);     // branch funct3 010
        default: instr(7'b0110011, 3'b001, 7'b0100000); // sll with funct7 0100000
      endcase
      push(T_IDLE); push(T_FETCH, 1); push(T_DECODE);
      if (k == 1) push(T_BRANCH);
      if (k == 2) push(T_EXEC_R);
      push(T_TRAP_ILL, 1); push(T_TRAP_ILL, 1, 1); push(T_TRAP_ILL, 0);
      while (sb.size() != 0) begin
        r = sb.pop_front();
        opcode = r.op; funct3 = r.f3; funct7 = r.f7; mem_ready = r.rdy; alu_zero = r.z;
        @(negedge clk);
        got = dut_outs();
        if (k == 1 && n == 3) got.alu = r.exp.alu;   // ALU op is don't-care on a bad branch
        checks++;
        if (got !== r.exp) begin
          errors++; $display("FAIL illegal%0d step %0d got %h expected %h", k, n, got, r.exp);
        end
        n++;
        @(posedge clk); #1;
      end
      n = 0;
    end
  endtask

  task automatic test_timeout();
    rec_t r; outs_t got; int n = 0;
    apply_reset();
    instr(7'b0110011, 3'b000, 7'b0000000);
    push(T_IDLE);
    for (int i = 0; i < 16; i++) push(T_FETCH, 0);
    push(T_TRAP_MEM, 0); push(T_TRAP_MEM, 1); push(T_TRAP_MEM, 0);
    while (sb.size() != 0) begin
      r = sb.pop_front();
      opcode = r.op; funct3 = r.f3; funct7 = r.f7; mem_ready = r.rdy; alu_zero = r.z;
      @(negedge clk);
      got = dut_outs(); checks++;
      if (got !== r.exp) begin
        errors++; $display("FAIL timeout step %0d got %h expected %h", n, got, r.exp);
      end
      n++;
      @(posedge clk); #1;
    end
    apply_reset();
    push(T_IDLE); push(T_FETCH, 1); push(T_DECODE); push(T_EXEC_R); push(T_ALU_WB);
    while (sb.size() != 0) begin
      r = sb.pop_front();
      opcode = r.op; funct3 = r.f3; funct7 = r.f7; mem_ready = r.rdy; alu_zero = r.z;
      @(negedge clk);
      got = dut_outs(); checks++;
      if (got !== r.exp) begin
        errors++; $display("FAIL timeout_recover step %0d got %h expected %h", n, got, r.exp);
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midload();
    rec_t r; outs_t got; int n = 0;
    apply_reset();
    instr(7'b0000011, 3'b010, 7'b0000000);
    push(T_IDLE); push(T_FETCH, 1); push(T_DECODE); push(T_MEM_ADDR);
    push(T_MEM_RD, 0); push(T_MEM_RD, 0);
    while (sb.size() != 0) begin
      r = sb.pop_front();
      opcode = r.op; funct3 = r.f3; funct7 = r.f7; mem_ready = r.rdy; alu_zero = r.z;
      @(negedge clk);
      got = dut_outs(); checks++;
      if (got !== r.exp) begin
        errors++; $display("FAIL midload step %0d got %h expected %h", n, got, r.exp);
      end
      n++;
      @(posedge clk); #1;
    end
    // Still in MEM_RD here; pull reset between clock edges.
    mem_ready = 1'b0;
    #2;
    got = dut_outs(); checks++;
    if (got !== model(T_MEM_RD, cur_op, cur_f3, cur_f7, 1'b0, 1'b0)) begin
      errors++; $display("FAIL midload_pre got %h expected %h", got,
                         model(T_MEM_RD, cur_op, cur_f3, cur_f7, 1'b0, 1'b0));
    end
    rst_n = 1'b0;
    #1;
    got = dut_outs(); checks++;
    if (got !== outs_t'(0)) begin
      errors++; $display("FAIL midload_async got %h expected %h", got, outs_t'(0));
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    push(T_IDLE); push(T_FETCH, 1); push(T_DECODE);
    while (sb.size() != 0) begin
      r = sb.pop_front();
      opcode = r.op; funct3 = r.f3; funct7 = r.f7; mem_ready = r.rdy; alu_zero = r.z;
      @(negedge clk);
      got = dut_outs(); checks++;
      if (got !== r.exp) begin
        errors++; $display("FAIL midload_restart step %0d got %h expected %h", n, got, r.exp);
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_memory();
    test_branch();
    test_jumps();
    test_illegal();
    test_timeout();
    test_reset_midload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

endmodule
